vector_mem_arbiter: RTL and testbench
=====================================

Name: vector_mem_arbiter

Overview:
- Shares one memory request port between NUM_PORTS vector load/store units.
- Arbitrates round-robin at vector-access granularity: the winning port stays locked until all access_length beats of its access have been accepted.
- Owns a one-entry registered output stage toward memory.
- Routes memory responses back to the issuing port by core_id.

Parameters:
NUM_PORTS, 4, number of load/store unit requesters
CORE_ID_BASE, 8, core_id of port 0; port i carries core_id CORE_ID_BASE+i

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
port_req[NUM_PORTS]  input  request_t  per-port memory request (vld, access_type, access_length, access_id, core_id, addr, byte_en, data)
port_grant[NUM_PORTS]  output  1 each  beat accepted from port i this cycle (combinational)
port_rsp[NUM_PORTS]  output  request_t  per-port routed memory response
mem_req  output  request_t  registered request to memory
mem_grant  input  1  memory accepted mem_req this cycle
mem_rsp  input  request_t  memory response
err_unmapped  output  1  one-cycle pulse: response core_id outside the port range

Behaviour:
- Reset (synchronous, active-high) clears the following on the next clk edge, including mid-burst; no beat is held across reset.
  - Outputs: mem_req=0, port_rsp[*]=0, err_unmapped=0; port_grant=0 (state is IDLE).
  - Internal: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
- IDLE state:
  - Pick the first i with port_req[i].vld, searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - On the next edge: owner<=i, beat_cnt<=0, len<=max(port_req[i].access_length,1), state<=BURST.
  - No grants are issued in IDLE. If no port is valid, stay in IDLE.
- BURST state:
  - port_grant[owner] = port_req[owner].vld && (!mem_req.vld || mem_grant). All other grants are 0.
  - On a grant: mem_req<=port_req[owner] and beat_cnt<=beat_cnt+1.
  - On mem_grant with no new grant: mem_req<=0 (vld drops).
  - If mem_req.vld && !mem_grant: hold mem_req unchanged; no grant is issued.
  - Owner drops vld mid-burst: the lock is held, no other port is served, and the arbiter waits.
  - A grant with beat_cnt+1==len ends the access: state<=IDLE, rr_ptr<=owner+1 (wraps to 0 after NUM_PORTS-1). The last beat drains from mem_req independently.
- Latency:
  - A request in IDLE at cycle 0 is granted at cycle 1, and mem_req.vld rises at cycle 2.
  - Back-to-back beats of the same owner proceed one per cycle while mem_grant is held high.
  - Each change of owner costs one IDLE cycle.
- Width: beat_cnt and len are REQUEST_COUNTER_WIDTH wide. access_length=0 is treated as 1 beat.
- Response routing (independent of the arbitration state):
  - When mem_rsp.vld and idx=mem_rsp.core_id-CORE_ID_BASE is in 0..NUM_PORTS-1: port_rsp[idx]<=mem_rsp, and every other port_rsp[*].vld<=0. Latency is 1 cycle.
  - When the core_id is out of range: drop the response, pulse err_unmapped, and set all port_rsp vld to 0.
  - Response routing has no backpressure.
- Simultaneous events:
  - A response arriving during any request phase is unaffected.
  - The end of a burst and a new request from the same port: that port has the lowest priority in the next arbitration.

Decomposition:
- Shared package holds: request_t, READ_REQ/WRITE_REQ, REQUEST_COUNTER_WIDTH, and a new NUM_PORTS default constant.
- Sub-module rr_arbiter: rotating-priority picker with inputs req vector and rr_ptr, outputs one-hot gnt and index. Pure combinational; it is instantiated once.

Test Plan:
- Single port 0, WRITE, access_length=4, mem_grant tied 1 -> port_grant[0] high in cycles 1-4; mem_req.addr sequence 0,1,2,3 in cycles 2-5; state returns to IDLE after cycle 4.
- Ports 1 and 3 request simultaneously with rr_ptr=0, length 2 each -> all of port 1's beats go first, then one IDLE cycle, then port 3; rr_ptr ends at 0.
- Port 2 burst of length 3 with mem_grant low for 3 cycles after the first beat -> mem_req is held stable; no port_grant during the stall; 3 beats total, none duplicated or lost.
- mem_rsp.vld with core_id=10, then core_id=20 -> port_rsp[2] is valid one cycle later; then err_unmapped pulses and all port_rsp vld are 0.
- reset asserted after 2 of 5 beats -> next cycle mem_req=0 and state IDLE; a fresh request is granted from rr_ptr=0.
- access_length=0 on port 0 -> exactly one beat is granted, then IDLE.

Source files
------------

// File: rtl/vector_mem_arbiter_pkg.sv
// Shared types and constants for the vector memory arbiter and its load/store clients.
package vector_mem_arbiter_pkg;

  localparam int unsigned REQUEST_COUNTER_WIDTH = 8;
  localparam int unsigned NUM_PORTS_DEFAULT     = 4;
  localparam int unsigned CORE_ID_WIDTH         = 8;
  localparam int unsigned ACCESS_ID_WIDTH       = 4;
  localparam int unsigned ADDR_WIDTH            = 32;
  localparam int unsigned DATA_WIDTH            = 64;
  localparam int unsigned BYTE_EN_WIDTH         = DATA_WIDTH / 8;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_e;

  typedef struct packed {
    logic                             vld;
    access_type_e                     access_type;
    logic [REQUEST_COUNTER_WIDTH-1:0] access_length;
    logic [ACCESS_ID_WIDTH-1:0]       access_id;
    logic [CORE_ID_WIDTH-1:0]         core_id;
    logic [ADDR_WIDTH-1:0]            addr;
    logic [BYTE_EN_WIDTH-1:0]         byte_en;
    logic [DATA_WIDTH-1:0]            data;
  } request_t;

endpackage

// File: rtl/vector_mem_arbiter_rr_arbiter.sv
// Rotating-priority picker: first asserted request at or after rr_ptr, wrapping around.
module vector_mem_arbiter_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IdxW-1:0]      rr_ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IdxW-1:0]      idx
);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] pos;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      pos = IdxW'((32'(rr_ptr) + k) % NUM_PORTS);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter sharing one registered memory request port among vector LSUs,
// locked per access, with core_id-based response routing back to the ports.
module vector_mem_arbiter
  import vector_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = NUM_PORTS_DEFAULT,
  parameter int unsigned CORE_ID_BASE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             port_req [NUM_PORTS],
  output logic [NUM_PORTS-1:0] port_grant,
  output request_t             port_rsp [NUM_PORTS],
  output request_t             mem_req,
  input  logic                 mem_grant,
  input  request_t             mem_rsp,
  output logic                 err_unmapped
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW = REQUEST_COUNTER_WIDTH;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0] len_q, len_d;
  request_t        mem_req_q, mem_req_d;
  request_t        port_rsp_q [NUM_PORTS];
  request_t        port_rsp_d [NUM_PORTS];
  logic            err_q, err_d;

  logic [NUM_PORTS-1:0] req_vld;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic [IdxW-1:0]      arb_idx;
  logic                 grant;
  request_t             owner_req;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      req_vld[i] = port_req[i].vld;
    end
  end

  vector_mem_arbiter_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_arbiter (
    .req   (req_vld),
    .rr_ptr(rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  assign owner_req = port_req[owner_q];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    port_grant = '0;
    grant      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          owner_d    = arb_idx;
          beat_cnt_d = '0;
          len_d      = (port_req[arb_idx].access_length == '0) ? CntOne
                                                               : port_req[arb_idx].access_length;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        // The output stage can take a beat when empty or draining this cycle.
        grant = owner_req.vld && (!mem_req_q.vld || mem_grant);
        if (grant) begin
          beat_cnt_d = beat_cnt_q + CntOne;
          if (beat_cnt_q + CntOne == len_q) begin
            state_d  = StIdle;
            rr_ptr_d = (owner_q == IdxW'(NUM_PORTS - 1)) ? '0 : owner_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    port_grant[owner_q] = grant;

    mem_req_d = mem_req_q;
    if (grant) begin
      mem_req_d = owner_req;
    end else if (mem_grant) begin
      mem_req_d = '0;
    end
  end

  always_comb begin
    int   rsp_off;
    logic rsp_hit;
    rsp_off = int'(mem_rsp.core_id) - int'(CORE_ID_BASE);
    rsp_hit = mem_rsp.vld && (rsp_off >= 0) && (rsp_off < int'(NUM_PORTS));
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      port_rsp_d[i]     = port_rsp_q[i];
      port_rsp_d[i].vld = 1'b0;
      if (rsp_hit && (rsp_off == i)) begin
        port_rsp_d[i] = mem_rsp;
      end
    end
    err_d = mem_rsp.vld && !rsp_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      mem_req_q  <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        port_rsp_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      mem_req_q  <= mem_req_d;
      err_q      <= err_d;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        port_rsp_q[i] <= port_rsp_d[i];
      end
    end
  end

  assign mem_req      = mem_req_q;
  assign port_rsp     = port_rsp_q;
  assign err_unmapped = err_q;

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed bench for vector_mem_arbiter: bursts, stalls, round-robin order, reset, responses.
module tb_vector_mem_arbiter;
  import vector_mem_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  request_t   port_req [4];
  logic [3:0] port_grant;
  request_t   port_rsp [4];
  request_t   mem_req;
  logic       mem_grant;
  request_t   mem_rsp;
  logic       err_unmapped;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  vector_mem_arbiter #(
    .NUM_PORTS   (4),
    .CORE_ID_BASE(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .port_req    (port_req),
    .port_grant  (port_grant),
    .port_rsp    (port_rsp),
    .mem_req     (mem_req),
    .mem_grant   (mem_grant),
    .mem_rsp     (mem_rsp),
    .err_unmapped(err_unmapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    assert (got === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle's grant vector and memory-side request at the falling edge.
  task automatic ecyc(input string tag, input logic [3:0] g, input logic v, input logic [31:0] a);
    @(negedge clk);
    chk({tag, ".grant"}, 64'(port_grant), 64'(g));
    chk({tag, ".vld"}, 64'(mem_req.vld), 64'(v));
    if (v) chk({tag, ".addr"}, 64'(mem_req.addr), 64'(a));
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input int len, input logic [31:0] addr);
    port_req[p]               = '0;
    port_req[p].vld           = 1'b1;
    port_req[p].access_type   = WRITE_REQ;
    port_req[p].access_length = REQUEST_COUNTER_WIDTH'(len);
    port_req[p].core_id       = CORE_ID_WIDTH'(8 + p);
    port_req[p].addr          = addr;
    port_req[p].byte_en       = '1;
    port_req[p].data          = 64'(addr);
  endtask

  initial begin
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    mem_grant = 1'b1;
    mem_rsp   = '0;
    for (int p = 0; p < 4; p++) port_req[p] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.grant", 64'(port_grant), 64'(0));
    chk("rst.mem_req_zero", 64'(mem_req == '0), 64'(1));
    chk("rst.err", 64'(err_unmapped), 64'(0));
    for (int p = 0; p < 4; p++) chk($sformatf("rst.rsp%0d_vld", p), 64'(port_rsp[p].vld), 64'(0));
    next_cyc();

    // Single port 0 WRITE burst of 4, memory always ready
    set_req(0, 4, 32'h0);
    ecyc("t1.c0", 4'b0000, 1'b0, 32'h0);
    next_cyc();
    for (int i = 1; i <= 4; i++) begin
      ecyc($sformatf("t1.c%0d", i), 4'b0001, i > 1, 32'(i - 2));
      next_cyc();
      if (i < 4) port_req[0].addr = 32'(i);
      else port_req[0].vld = 1'b0;
    end
    ecyc("t1.c5", 4'b0000, 1'b1, 32'h3);
    next_cyc();
    ecyc("t1.c6", 4'b0000, 1'b0, 32'h0);
    next_cyc();

    // access_length 0 is one beat; holding vld starts a second one-beat access
    set_req(0, 0, 32'h60);
    ecyc("t6.c0", 4'b0000, 1'b0, 32'h0);
    next_cyc();
    ecyc("t6.c1", 4'b0001, 1'b0, 32'h0);
    next_cyc();
    ecyc("t6.c2", 4'b0000, 1'b1, 32'h60);
    next_cyc();
    ecyc("t6.c3", 4'b0001, 1'b0, 32'h0);
    next_cyc();
    port_req[0].vld = 1'b0;
    ecyc("t6.c4", 4'b0000, 1'b1, 32'h60);
    next_cyc();
    ecyc("t6.c5", 4'b0000, 1'b0, 32'h0);
    next_cyc();

    // Port 2 burst of 3 with a 3-cycle memory stall after the first beat
    set_req(2, 3, 32'h20);
    ecyc("t3.c0", 4'b0000, 1'b0, 32'h0);
    next_cyc();
    ecyc("t3.c1", 4'b0100, 1'b0, 32'h0);
    next_cyc();
    port_req[2].addr = 32'h21;
    mem_grant = 1'b0;
    ecyc("t3.c2", 4'b0000, 1'b1, 32'h20);
    next_cyc();
    ecyc("t3.c3", 4'b0000, 1'b1, 32'h20);
    next_cyc();
    ecyc("t3.c4", 4'b0000, 1'b1, 32'h20);
    next_cyc();
    mem_grant = 1'b1;
    ecyc("t3.c5", 4'b0100, 1'b1, 32'h20);
    next_cyc();
    port_req[2].addr = 32'h22;
    ecyc("t3.c6", 4'b0100, 1'b1, 32'h21);
    next_cyc();
    port_req[2].vld = 1'b0;
    ecyc("t3.c7", 4'b0000, 1'b1, 32'h22);
    next_cyc();
    ecyc("t3.c8", 4'b0000, 1'b0, 32'h0);
    next_cyc();

    // Reset after 2 of 5 beats; rr pointer (3 before reset) must restart at 0
    set_req(2, 5, 32'h50);
    ecyc("t5.c0", 4'b0000, 1'b0, 32'h0);
    next_cyc();
    ecyc("t5.c1", 4'b0100, 1'b0, 32'h0);
    next_cyc();
    port_req[2].addr = 32'h51;
    ecyc("t5.c2", 4'b0100, 1'b1, 32'h50);
    next_cyc();
    port_req[2].addr = 32'h52;
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    port_req[2].vld = 1'b0;
    set_req(1, 2, 32'h10);
    set_req(3, 2, 32'h30);
    ecyc("t5.after_reset", 4'b0000, 1'b0, 32'h0);
    next_cyc();

    // Ports 1 and 3 together: port 1 first, one IDLE cycle, then port 3
    ecyc("t2.c1", 4'b0010, 1'b0, 32'h0);
    next_cyc();
    port_req[1].addr = 32'h11;
    ecyc("t2.c2", 4'b0010, 1'b1, 32'h10);
    next_cyc();
    port_req[1].vld = 1'b0;
    ecyc("t2.c3", 4'b0000, 1'b1, 32'h11);
    next_cyc();
    ecyc("t2.c4", 4'b1000, 1'b0, 32'h0);
    next_cyc();
    port_req[3].addr = 32'h31;
    ecyc("t2.c5", 4'b1000, 1'b1, 32'h30);
    next_cyc();
    port_req[3].vld = 1'b0;
    ecyc("t2.c6", 4'b0000, 1'b1, 32'h31);
    next_cyc();
    // rr pointer wrapped to 0: port 0 beats port 3, then port 3 is served
    set_req(0, 1, 32'h70);
    set_req(3, 1, 32'h71);
    ecyc("t2.c7", 4'b0000, 1'b0, 32'h0);
    next_cyc();
    ecyc("t2.c8", 4'b0001, 1'b0, 32'h0);
    next_cyc();
    port_req[0].vld = 1'b0;
    ecyc("t2.c9", 4'b0000, 1'b1, 32'h70);
    next_cyc();
    ecyc("t2.c10", 4'b1000, 1'b0, 32'h0);
    next_cyc();
    port_req[3].vld = 1'b0;
    ecyc("t2.c11", 4'b0000, 1'b1, 32'h71);
    next_cyc();

    // Response routing: core_id 10 -> port 2, core_id 20 -> unmapped
    mem_rsp           = '0;
    mem_rsp.vld       = 1'b1;
    mem_rsp.core_id   = 8'd10;
    mem_rsp.access_id = 4'h5;
    mem_rsp.data      = 64'hAB;
    @(negedge clk);
    chk("t4.rsp2_same_cycle", 64'(port_rsp[2].vld), 64'(0));
    next_cyc();
    mem_rsp.core_id = 8'd20;
    mem_rsp.data    = 64'hCD;
    @(negedge clk);
    chk("t4.rsp2_vld", 64'(port_rsp[2].vld), 64'(1));
    chk("t4.rsp2_data", port_rsp[2].data, 64'hAB);
    chk("t4.rsp2_id", 64'(port_rsp[2].access_id), 64'h5);
    for (int p = 0; p < 4; p++) begin
      if (p != 2) chk($sformatf("t4.rsp%0d_vld", p), 64'(port_rsp[p].vld), 64'(0));
    end
    chk("t4.err_idle", 64'(err_unmapped), 64'(0));
    next_cyc();
    mem_rsp = '0;
    @(negedge clk);
    chk("t4.err_pulse", 64'(err_unmapped), 64'(1));
    for (int p = 0; p < 4; p++) chk($sformatf("t4.drop_rsp%0d_vld", p), 64'(port_rsp[p].vld), 64'(0));
    next_cyc();
    @(negedge clk);
    chk("t4.err_clear", 64'(err_unmapped), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
